// File: rtl/rand_key_pkg.sv
// Shared types and constants for the random AES key builder.
// Optional word rejection is enabled with `define RAND_REPEAT_CHECK_EN.
package rand_key_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        CAPT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int RND_WORD_W   = 64;
    localparam int REP_ERR_W    = 8;
    localparam int KEY_BITS_128 = 128;
    localparam int KEY_BITS_192 = 192;
    localparam int KEY_BITS_256 = 256;

    function automatic logic key_bits_legal(input int kb);
        return (kb == KEY_BITS_128) || (kb == KEY_BITS_192) || (kb == KEY_BITS_256);
    endfunction

endpackage

// File: rtl/rand_key_shreg.sv
// Key slot register: WORDS x 64-bit slots, slot 0 occupies the key MSBs.
module rand_key_shreg
    import rand_key_pkg::*;
#(
    parameter int WORDS = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        wr_en,
    input  logic [1:0]                  wr_idx,
    input  logic [RND_WORD_W-1:0]       wr_data,
    output logic [WORDS*RND_WORD_W-1:0] data
);

    logic [RND_WORD_W-1:0] slot [WORDS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) slot[i] <= '0;
        end else if (wr_en) begin
            slot[wr_idx] <= wr_data;
        end
    end

    // First-captured word is the most significant slice of the key.
    always_comb begin
        data = '0;
        for (int i = 0; i < WORDS; i++) begin
            data[(WORDS-i)*RND_WORD_W-1 -: RND_WORD_W] = slot[i];
        end
    end

endmodule

// File: rtl/rand_key_builder.sv
// Sequences LFSR word requests and assembles them into an AES key.
// `define RAND_REPEAT_CHECK_EN rejects repeated, all-zero and all-one words.
module rand_key_builder
    import rand_key_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rnd_ready,
    input  logic [RND_WORD_W-1:0] rnd_data,
    output logic [KEY_BITS-1:0]   key_out,
    output logic                  key_valid,
    input  logic                  key_ready,
    output logic                  busy,
    output logic [REP_ERR_W-1:0]  rep_err
);

    localparam int         WORDS = KEY_BITS / RND_WORD_W;
    localparam logic [1:0] LAST  = 2'(WORDS - 1);

    state_t     state, state_nxt;
    logic [1:0] cnt;
    logic       word_ok;
    logic       wr_en;

`ifdef RAND_REPEAT_CHECK_EN
    logic [RND_WORD_W-1:0] prev_word;
    logic [REP_ERR_W-1:0]  rep_cnt;

    assign word_ok = (rnd_data != prev_word) && (rnd_data != '0) && (rnd_data != '1);

    // prev_word survives across keys; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_word <= '0;
            rep_cnt   <= '0;
        end else if (state == CAPT) begin
            if (word_ok) begin
                prev_word <= rnd_data;
            end else if (rep_cnt != '1) begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    assign rep_err = rep_cnt;
`else
    assign word_ok = 1'b1;
    assign rep_err = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                cnt <= '0;
            end else if (state == CAPT && word_ok && cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        rnd_ready = 1'b0;
        key_valid = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = REQ;
            REQ: begin
                rnd_ready = 1'b1;
                state_nxt = CAPT;
            end
            CAPT: begin
                wr_en     = word_ok;
                state_nxt = (word_ok && cnt == LAST) ? DONE : REQ;
            end
            DONE: begin
                key_valid = 1'b1;
                if (key_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    rand_key_shreg #(
        .WORDS(WORDS)
    ) u_shreg (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_idx  (cnt),
        .wr_data (rnd_data),
        .data    (key_out)
    );

endmodule

// File: tb/tb_rand_key_builder.sv
// Directed bench for rand_key_builder: a 128-bit and a 256-bit instance side by side.
module tb_rand_key_builder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_a = 1'b0, reset_b = 1'b0;
    logic         start_a = 1'b0, start_b = 1'b0;
    logic         key_ready_a = 1'b0, key_ready_b = 1'b0;
    logic         rnd_ready_a, rnd_ready_b;
    logic [63:0]  rnd_data_a = '0, rnd_data_b = '0;
    logic [127:0] key_out_a;
    logic [255:0] key_out_b;
    logic         key_valid_a, key_valid_b;
    logic         busy_a, busy_b;
    logic [7:0]   rep_err_a, rep_err_b;

    rand_key_builder #(.KEY_BITS(128)) dut_a (
        .clk(clk), .reset(reset_a), .start(start_a), .rnd_ready(rnd_ready_a),
        .rnd_data(rnd_data_a), .key_out(key_out_a), .key_valid(key_valid_a),
        .key_ready(key_ready_a), .busy(busy_a), .rep_err(rep_err_a)
    );

    rand_key_builder #(.KEY_BITS(256)) dut_b (
        .clk(clk), .reset(reset_b), .start(start_b), .rnd_ready(rnd_ready_b),
        .rnd_data(rnd_data_b), .key_out(key_out_b), .key_valid(key_valid_b),
        .key_ready(key_ready_b), .busy(busy_b), .rep_err(rep_err_b)
    );

    // Source models: a word list per instance, zero once the list runs out.
    logic [63:0] words_a [0:63];
    logic [63:0] words_b [0:63];
    int n_a = 0, n_b = 0;
    int idx_a = 0, idx_b = 0;
    int pulses_a = 0, pulses_b = 0;

    always @(posedge clk) begin
        if (rnd_ready_a) begin
            rnd_data_a <= (idx_a < n_a) ? words_a[idx_a] : 64'h0;
            idx_a      <= idx_a + 1;
            pulses_a   <= pulses_a + 1;
        end
        if (rnd_ready_b) begin
            rnd_data_b <= (idx_b < n_b) ? words_b[idx_b] : 64'h0;
            idx_b      <= idx_b + 1;
            pulses_b   <= pulses_b + 1;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [63:0] w);
        words_a[n_a] = w;
        n_a++;
    endtask

    initial begin
        int cyc;
        int p0;

        #1;
        chk("rst_rnd_ready", rnd_ready_a, 0);
        chk("rst_key_valid", key_valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_key_out", key_out_a, 0);
        chk("rst_rep_err", rep_err_a, 0);
        tick; tick;
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick;

        // 128-bit key, timing and pulse count
        push_a(64'h1111111111111111);
        push_a(64'h2222222222222222);
        p0 = pulses_a;
        start_a = 1'b1; tick; start_a = 1'b0;
        chk("k128_first_req", rnd_ready_a, 1);
        chk("k128_busy", busy_a, 1);
        cyc = 1;
        while (key_valid_a !== 1'b1 && cyc < 40) begin tick; cyc++; end
        chk("k128_valid_cycle", cyc, 5);
        chk("k128_key", key_out_a, 128'h1111111111111111_2222222222222222);
        chk("k128_pulses", pulses_a - p0, 2);
        key_ready_a = 1'b1; tick; key_ready_a = 1'b0;
        chk("k128_accept_valid", key_valid_a, 0);
        chk("k128_accept_busy", busy_a, 0);
        chk("k128_key_kept", key_out_a, 128'h1111111111111111_2222222222222222);

        // start pulses during CAPT and DONE are ignored
        push_a(64'h3333333333333333);
        push_a(64'h4444444444444444);
        p0 = pulses_a;
        start_a = 1'b1; tick; start_a = 1'b0;
        tick;
        start_a = 1'b1; tick; start_a = 1'b0;
        chk("ign_req2", rnd_ready_a, 1);
        cyc = 3;
        while (key_valid_a !== 1'b1 && cyc < 40) begin tick; cyc++; end
        chk("ign_valid_cycle", cyc, 5);
        start_a = 1'b1; tick; tick;
        chk("ign_done_valid", key_valid_a, 1);
        chk("ign_pulses", pulses_a - p0, 2);
        key_ready_a = 1'b1; tick;
        start_a = 1'b0; key_ready_a = 1'b0;
        chk("both_busy", busy_a, 0);
        chk("both_valid", key_valid_a, 0);
        tick;
        chk("both_not_queued", busy_a, 0);
        chk("both_no_req", rnd_ready_a, 0);
        chk("ign_key", key_out_a, 128'h3333333333333333_4444444444444444);

        // reset mid-sequence, then a clean key
        push_a(64'h9999999999999999);
        push_a(64'h7777777777777777);
        push_a(64'h8888888888888888);
        start_a = 1'b1; tick; start_a = 1'b0;
        tick; tick;
        reset_a = 1'b0; #1;
        chk("mid_rst_rnd_ready", rnd_ready_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_valid", key_valid_a, 0);
        chk("mid_rst_key", key_out_a, 0);
        chk("mid_rst_rep_err", rep_err_a, 0);
        tick; reset_a = 1'b1; tick;
        start_a = 1'b1; tick; start_a = 1'b0;
        cyc = 1;
        while (key_valid_a !== 1'b1 && cyc < 40) begin tick; cyc++; end
        chk("post_rst_cycle", cyc, 5);
        chk("post_rst_key", key_out_a, 128'h7777777777777777_8888888888888888);
        key_ready_a = 1'b1; tick; key_ready_a = 1'b0;

        // 256-bit key, held valid while not accepted
        words_b[0] = 64'hAAAAAAAAAAAAAAAA;
        words_b[1] = 64'hBBBBBBBBBBBBBBBB;
        words_b[2] = 64'hCCCCCCCCCCCCCCCC;
        words_b[3] = 64'hDDDDDDDDDDDDDDDD;
        n_b = 4;
        start_b = 1'b1; tick; start_b = 1'b0;
        cyc = 1;
        while (key_valid_b !== 1'b1 && cyc < 60) begin tick; cyc++; end
        chk("k256_valid_cycle", cyc, 9);
        chk("k256_key", key_out_b,
            256'hAAAAAAAAAAAAAAAA_BBBBBBBBBBBBBBBB_CCCCCCCCCCCCCCCC_DDDDDDDDDDDDDDDD);
        chk("k256_pulses", pulses_b, 4);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("k256_hold", key_valid_b, 1);
        end
        key_ready_b = 1'b1; tick; key_ready_b = 1'b0;
        chk("k256_drop", key_valid_b, 0);
        chk("k256_idle", busy_b, 0);

`ifdef RAND_REPEAT_CHECK_EN
        // repeated and all-zero words are rejected
        push_a(64'h5555555555555555);
        push_a(64'h5555555555555555);
        push_a(64'h0000000000000000);
        push_a(64'h6666666666666666);
        p0 = pulses_a;
        start_a = 1'b1; tick; start_a = 1'b0;
        cyc = 1;
        while (key_valid_a !== 1'b1 && cyc < 60) begin tick; cyc++; end
        chk("rep_valid", key_valid_a, 1);
        chk("rep_key", key_out_a, 128'h5555555555555555_6666666666666666);
        chk("rep_err_cnt", rep_err_a, 2);
        chk("rep_pulses", pulses_a - p0, 4);
        key_ready_a = 1'b1; tick; key_ready_a = 1'b0;

        // stuck-at-zero source saturates the error counter
        start_a = 1'b1; tick; start_a = 1'b0;
        repeat (620) tick;
        chk("sat_rep_err", rep_err_a, 255);
        chk("sat_valid", key_valid_a, 0);
        chk("sat_busy", busy_a, 1);
        reset_a = 1'b0; tick; reset_a = 1'b1; tick;
        chk("sat_rst_rep_err", rep_err_a, 0);
`else
        chk("rep_err_tied_a", rep_err_a, 0);
        chk("rep_err_tied_b", rep_err_b, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
